regblock_mem_wb_pipe: RTL and testbench

- Parametrised, elastic successor of the execute/memory-to-write-back pipeline register for the Custom19 core.
- Carries ALU result, load data and write-back control from the memory stage to the register-file write port.
- Adds valid/ready flow control with a one-entry skid buffer, pipeline flush, an internal write-back mux, forwarding lookup and a saturating stall counter.
- Sits between the load/store unit and the register file.

---
 rtl/regblock_mem_wb_pipe.sv | 148 ++++++++++++++
 tb/tb_regblock_mem_wb_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regblock_mem_wb_pipe.sv
// Memory-to-write-back pipeline register with valid/ready handshake, one-entry skid buffer,
// flush, write-back data mux, forwarding lookup and a saturating stall counter.
module regblock_mem_wb_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] ld_data_in,
  input  logic [ADDR_W-1:0] wb_addr_in,
  input  logic              wr_back_sel_in,
  input  logic              reg_wr_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] ld_data_out,
  output logic [ADDR_W-1:0] wb_addr_out,
  output logic              wr_back_sel_out,
  output logic              reg_wr_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              wb_en_out,
  input  logic [ADDR_W-1:0] fwd_addr_in,
  output logic              fwd_hit_out,
  output logic [DATA_W-1:0] fwd_data_out,
  output logic [CNT_W-1:0]  stall_cnt_out
);

  logic [DATA_W-1:0] m_alu_q, m_alu_d, m_ld_q, m_ld_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_sel_q, m_sel_d, m_rw_q, m_rw_d, mv_q, mv_d;
  logic [DATA_W-1:0] s_alu_q, s_alu_d, s_ld_q, s_ld_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic              s_sel_q, s_sel_d, s_rw_q, s_rw_d, sv_q, sv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign accept = valid_in & ~sv_q;

  always_comb begin
    m_alu_d  = m_alu_q;
    m_ld_d   = m_ld_q;
    m_addr_d = m_addr_q;
    m_sel_d  = m_sel_q;
    m_rw_d   = m_rw_q;
    mv_d     = mv_q;
    s_alu_d  = s_alu_q;
    s_ld_d   = s_ld_q;
    s_addr_d = s_addr_q;
    s_sel_d  = s_sel_q;
    s_rw_d   = s_rw_q;
    sv_d     = sv_q;
    cnt_d    = cnt_q;
    if (flush_in) begin
      // Payload is left in place; only the valid bits are dropped.
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (mv_q && !ready_in) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (accept) begin
        s_alu_d  = alu_result_in;
        s_ld_d   = ld_data_in;
        s_addr_d = wb_addr_in;
        s_sel_d  = wr_back_sel_in;
        s_rw_d   = reg_wr_in;
        sv_d     = 1'b1;
      end
    end else if (sv_q) begin
      m_alu_d  = s_alu_q;
      m_ld_d   = s_ld_q;
      m_addr_d = s_addr_q;
      m_sel_d  = s_sel_q;
      m_rw_d   = s_rw_q;
      mv_d     = 1'b1;
      sv_d     = 1'b0;
    end else if (accept) begin
      m_alu_d  = alu_result_in;
      m_ld_d   = ld_data_in;
      m_addr_d = wb_addr_in;
      m_sel_d  = wr_back_sel_in;
      m_rw_d   = reg_wr_in;
      mv_d     = 1'b1;
    end else begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_alu_q  <= '0;
      m_ld_q   <= '0;
      m_addr_q <= '0;
      m_sel_q  <= 1'b0;
      m_rw_q   <= 1'b0;
      mv_q     <= 1'b0;
      s_alu_q  <= '0;
      s_ld_q   <= '0;
      s_addr_q <= '0;
      s_sel_q  <= 1'b0;
      s_rw_q   <= 1'b0;
      sv_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      m_alu_q  <= m_alu_d;
      m_ld_q   <= m_ld_d;
      m_addr_q <= m_addr_d;
      m_sel_q  <= m_sel_d;
      m_rw_q   <= m_rw_d;
      mv_q     <= mv_d;
      s_alu_q  <= s_alu_d;
      s_ld_q   <= s_ld_d;
      s_addr_q <= s_addr_d;
      s_sel_q  <= s_sel_d;
      s_rw_q   <= s_rw_d;
      sv_q     <= sv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_out       = ~sv_q;
  assign valid_out       = mv_q;
  assign alu_result_out  = m_alu_q;
  assign ld_data_out     = m_ld_q;
  assign wb_addr_out     = m_addr_q;
  assign wr_back_sel_out = m_sel_q;
  assign reg_wr_out      = m_rw_q;
  assign wb_data_out     = m_sel_q ? m_ld_q : m_alu_q;
  assign wb_en_out       = mv_q & ready_in & m_rw_q;
  assign stall_cnt_out   = cnt_q;

  // Skid entry is younger than main, so it wins the lookup.
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    if (sv_q && s_rw_q && (s_addr_q == fwd_addr_in)) begin
      fwd_hit_out  = 1'b1;
      fwd_data_out = s_sel_q ? s_ld_q : s_alu_q;
    end else if (mv_q && m_rw_q && (m_addr_q == fwd_addr_in)) begin
      fwd_hit_out  = 1'b1;
      fwd_data_out = wb_data_out;
    end
  end

endmodule

// File: tb/tb_regblock_mem_wb_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_regblock_mem_wb_pipe;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] ld;
    logic [3:0]  addr;
    logic        sel;
    logic        rw;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, valid_in, ready_in;
  logic [15:0] alu_result_in, ld_data_in;
  logic [3:0]  wb_addr_in, fwd_addr_in;
  logic        wr_back_sel_in, reg_wr_in;
  logic        ready_out, valid_out, wr_back_sel_out, reg_wr_out, wb_en_out, fwd_hit_out;
  logic [15:0] alu_result_out, ld_data_out, wb_data_out, fwd_data_out;
  logic [3:0]  wb_addr_out;
  logic [7:0]  stall_cnt_out;
  logic        d2_ready, d2_valid, d2_sel, d2_rw, d2_wb_en, d2_hit;
  logic [15:0] d2_alu, d2_ld, d2_wb_data, d2_fwd_data;
  logic [3:0]  d2_addr;
  logic [1:0]  d2_stall;

  ent_t q[$];
  int   cnt, cnt2;
  int   n_tests = 0, n_fail = 0;

  always #5 clk_in = ~clk_in;

  regblock_mem_wb_pipe #(.DATA_W(16), .ADDR_W(4), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready_out), .alu_result_in(alu_result_in), .ld_data_in(ld_data_in),
    .wb_addr_in(wb_addr_in), .wr_back_sel_in(wr_back_sel_in), .reg_wr_in(reg_wr_in),
    .valid_out(valid_out), .ready_in(ready_in), .alu_result_out(alu_result_out),
    .ld_data_out(ld_data_out), .wb_addr_out(wb_addr_out), .wr_back_sel_out(wr_back_sel_out),
    .reg_wr_out(reg_wr_out), .wb_data_out(wb_data_out), .wb_en_out(wb_en_out),
    .fwd_addr_in(fwd_addr_in), .fwd_hit_out(fwd_hit_out), .fwd_data_out(fwd_data_out),
    .stall_cnt_out(stall_cnt_out)
  );

  regblock_mem_wb_pipe #(.DATA_W(16), .ADDR_W(4), .CNT_W(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(d2_ready), .alu_result_in(alu_result_in), .ld_data_in(ld_data_in),
    .wb_addr_in(wb_addr_in), .wr_back_sel_in(wr_back_sel_in), .reg_wr_in(reg_wr_in),
    .valid_out(d2_valid), .ready_in(ready_in), .alu_result_out(d2_alu),
    .ld_data_out(d2_ld), .wb_addr_out(d2_addr), .wr_back_sel_out(d2_sel),
    .reg_wr_out(d2_rw), .wb_data_out(d2_wb_data), .wb_en_out(d2_wb_en),
    .fwd_addr_in(fwd_addr_in), .fwd_hit_out(d2_hit), .fwd_data_out(d2_fwd_data),
    .stall_cnt_out(d2_stall)
  );

  function automatic logic [15:0] wb_of(ent_t e);
    return e.sel ? e.ld : e.alu;
  endfunction

  // Youngest held entry that writes the queried register supplies the data.
  function automatic void model_fwd(output logic hit, output logic [15:0] data);
    hit  = 1'b0;
    data = 16'h0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rw && q[i].addr == fwd_addr_in) begin
        hit  = 1'b1;
        data = wb_of(q[i]);
        break;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] ld,
                       input logic [3:0] addr, input logic sel, input logic rw);
    valid_in       = v;
    alu_result_in  = alu;
    ld_data_in     = ld;
    wb_addr_in     = addr;
    wr_back_sel_in = sel;
    reg_wr_in      = rw;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic step();
    ent_t e;
    bit   acc;
    @(posedge clk_in);
    if (rst_in) begin
      q.delete();
      cnt  = 0;
      cnt2 = 0;
    end else if (flush_in) begin
      q.delete();
    end else begin
      acc = valid_in && (q.size() < 2);
      e   = '{alu_result_in, ld_data_in, wb_addr_in, wr_back_sel_in, reg_wr_in};
      if (q.size() > 0 && !ready_in) begin
        if (cnt < 255) cnt++;
        if (cnt2 < 3) cnt2++;
      end
      if (q.size() > 0 && ready_in) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; flush_in = 1'b0; ready_in = 1'b1; fwd_addr_in = 4'h0;
    drive(1'b1, 16'h5A5A, 16'hA5A5, 4'h3, 1'b0, 1'b1);
    step();
    step();
    rst_in = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: valid=%b ready=%b, required 0/1", valid_out, ready_out);
    end
    n_tests++;
    if ({alu_result_out, ld_data_out, wb_addr_out, wr_back_sel_out, reg_wr_out, wb_data_out}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: alu=%h ld=%h addr=%h wb=%h, required all 0",
               alu_result_out, ld_data_out, wb_addr_out, wb_data_out);
    end
    n_tests++;
    if (wb_en_out !== 1'b0 || fwd_hit_out !== 1'b0 || fwd_data_out !== 16'h0
        || stall_cnt_out !== 8'h0 || d2_stall !== 2'h0) begin
      n_fail++;
      $display("FAIL reset_misc: wb_en=%b hit=%b fdata=%h stall=%0d/%0d, required 0",
               wb_en_out, fwd_hit_out, fwd_data_out, stall_cnt_out, d2_stall);
    end
  endtask

  task automatic test_streaming();
    int en_cycles = 0;
    ready_in = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, 16'h0011 + 16'(i), 16'h0, 4'(i + 1), 1'b0, 1'b1);
      else drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
      #1;
      if (wb_en_out === 1'b1) en_cycles++;
      if (i > 0) begin
        n_tests++;
        if (valid_out !== 1'b1 || wb_data_out !== 16'h0011 + 16'(i - 1)
            || wb_addr_out !== 4'(i)) begin
          n_fail++;
          $display("FAIL stream_%0d: valid=%b wb_data=%h addr=%h, required 1/%h/%h", i,
                   valid_out, wb_data_out, wb_addr_out, 16'h0011 + 16'(i - 1), 4'(i));
        end
      end
      step();
    end
    #1;
    n_tests++;
    if (en_cycles != 4 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: wb_en cycles=%0d valid=%b, required 4/0", en_cycles, valid_out);
    end
  endtask

  task automatic test_backpressure();
    int c0 = cnt;
    ready_in = 1'b0;
    drive(1'b1, 16'hA0A0, 16'h0, 4'h7, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'hB0B0, 16'h0, 4'h8, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (valid_out !== 1'b1 || alu_result_out !== 16'hA0A0 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_a_main: valid=%b alu=%h ready=%b, required 1/a0a0/1",
               valid_out, alu_result_out, ready_out);
    end
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (ready_out !== 1'b0 || alu_result_out !== 16'hA0A0 || stall_cnt_out !== 8'(c0 + 1)) begin
      n_fail++;
      $display("FAIL bp_held: ready=%b alu=%h stall=%0d, required 0/a0a0/%0d",
               ready_out, alu_result_out, stall_cnt_out, c0 + 1);
    end
    step();
    ready_in = 1'b1;
    #1;
    n_tests++;
    if (stall_cnt_out !== 8'(c0 + 2) || wb_en_out !== 1'b1 || alu_result_out !== 16'hA0A0) begin
      n_fail++;
      $display("FAIL bp_release_a: stall=%0d wb_en=%b alu=%h, required %0d/1/a0a0",
               stall_cnt_out, wb_en_out, alu_result_out, c0 + 2);
    end
    step();
    #1;
    n_tests++;
    if (alu_result_out !== 16'hB0B0 || valid_out !== 1'b1 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_b: alu=%h valid=%b ready=%b, required b0b0/1/1",
               alu_result_out, valid_out, ready_out);
    end
    step();
  endtask

  task automatic test_wb_mux();
    ready_in = 1'b1;
    drive(1'b1, 16'h1234, 16'hBEEF, 4'h2, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h1234, 16'hBEEF, 4'h2, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (wb_data_out !== 16'hBEEF || wb_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mux_load: wb_data=%h wb_en=%b, required beef/1", wb_data_out, wb_en_out);
    end
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (wb_data_out !== 16'hBEEF || wb_en_out !== 1'b0 || valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mux_nowr: wb_data=%h wb_en=%b valid=%b, required beef/0/1",
               wb_data_out, wb_en_out, valid_out);
    end
    step();
  endtask

  task automatic test_forwarding();
    ready_in = 1'b0;
    drive(1'b1, 16'h00AA, 16'h0, 4'h5, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'h00BB, 16'h0, 4'h5, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    fwd_addr_in = 4'h5;
    #1;
    n_tests++;
    if (fwd_hit_out !== 1'b1 || fwd_data_out !== 16'h00BB) begin
      n_fail++;
      $display("FAIL fwd_skid_prio: hit=%b data=%h, required 1/00bb", fwd_hit_out, fwd_data_out);
    end
    fwd_addr_in = 4'h6;
    #1;
    n_tests++;
    if (fwd_hit_out !== 1'b0 || fwd_data_out !== 16'h0) begin
      n_fail++;
      $display("FAIL fwd_miss: hit=%b data=%h, required 0/0000", fwd_hit_out, fwd_data_out);
    end
  endtask

  task automatic test_flush();
    // Buffer is full from the forwarding scenario.
    flush_in = 1'b1;
    drive(1'b1, 16'h0CCC, 16'h0, 4'h9, 1'b0, 1'b1);
    step();
    flush_in = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: valid=%b ready=%b, required 0/1", valid_out, ready_out);
    end
    step();
    #1;
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: valid=%b, required 0", valid_out);
    end
    ready_in = 1'b1;
    drive(1'b1, 16'h0DDD, 16'h0, 4'h1, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    flush_in = 1'b1;
    #1;
    n_tests++;
    if (wb_en_out !== 1'b1 || wb_data_out !== 16'h0DDD) begin
      n_fail++;
      $display("FAIL flush_fire: wb_en=%b data=%h, required 1/0ddd", wb_en_out, wb_data_out);
    end
    step();
    flush_in = 1'b0;
    #1;
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_fire_gone: valid=%b, required 0", valid_out);
    end
  endtask

  task automatic test_saturation();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    ready_in = 1'b0;
    drive(1'b1, 16'h0077, 16'h0, 4'h3, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    #1;
    n_tests++;
    if (d2_stall !== 2'd3 || stall_cnt_out !== 8'd6) begin
      n_fail++;
      $display("FAIL stall_sat: cnt2=%0d cnt8=%0d, required 3/6", d2_stall, stall_cnt_out);
    end
    ready_in = 1'b1;
    step();
    step();
  endtask

  task automatic test_random();
    logic        eh;
    logic [15:0] ed;
    for (int n = 0; n < 400; n++) begin
      rst_in      = ($urandom_range(0, 99) == 0);
      flush_in    = ($urandom_range(0, 19) == 0);
      ready_in    = ($urandom_range(0, 2) != 0);
      fwd_addr_in = 4'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      #1;
      model_fwd(eh, ed);
      n_tests++;
      if (valid_out !== (q.size() > 0) || ready_out !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rnd_hs @%0d: valid=%b ready=%b, required %b/%b", n, valid_out,
                 ready_out, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        n_tests++;
        if ({alu_result_out, ld_data_out, wb_addr_out, wr_back_sel_out, reg_wr_out} !== q[0]
            || wb_data_out !== wb_of(q[0])) begin
          n_fail++;
          $display("FAIL rnd_payload @%0d: alu=%h ld=%h addr=%h wb=%h, required %h/%h/%h/%h",
                   n, alu_result_out, ld_data_out, wb_addr_out, wb_data_out,
                   q[0].alu, q[0].ld, q[0].addr, wb_of(q[0]));
        end
      end
      n_tests++;
      if (wb_en_out !== (q.size() > 0 && ready_in && q[0].rw)) begin
        n_fail++;
        $display("FAIL rnd_wb_en @%0d: got %b", n, wb_en_out);
      end
      n_tests++;
      if (fwd_hit_out !== eh || fwd_data_out !== ed) begin
        n_fail++;
        $display("FAIL rnd_fwd @%0d: hit=%b data=%h, required %b/%h", n, fwd_hit_out,
                 fwd_data_out, eh, ed);
      end
      n_tests++;
      if (stall_cnt_out !== 8'(cnt) || d2_stall !== 2'(cnt2)) begin
        n_fail++;
        $display("FAIL rnd_stall @%0d: cnt=%0d/%0d, required %0d/%0d", n, stall_cnt_out,
                 d2_stall, cnt, cnt2);
      end
      step();
    end
  endtask

  initial begin
    cnt  = 0;
    cnt2 = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_wb_mux();
    test_forwarding();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
